fu_jump_pipe: RTL and testbench
===============================

Name: fu_jump_pipe

Overview:
- Parametrised branch/jump functional unit for the out-of-order core's jump issue slot. Successor to the fixed 32-bit, fixed-latency jump FU.
- Captures one issued branch, JAL or JALR operation and resolves comparison, taken flag, target and link value after a programmable latency.
- Result is presented with a tag and a one-cycle done pulse to the writeback/commit logic.
- Adds flush, busy back-pressure, unconditional JAL, JALR LSB clearing and target-misalignment detection.

Parameters:
- XLEN, 32: datapath width of operands, immediate, PC and results.
- LATENCY, 2: cycles from accept to done. Legal range is 1..8; elaboration fails outside it.
- TAG_W, 4: width of the issue tag carried through to the result.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- EN  in  1  issue valid; accepted only when busy=0.
- flush  in  1  synchronous kill of the in-flight op.
- JAL  in  1  unconditional PC-relative jump.
- JALR  in  1  register-indirect jump.
- cmp_ctrl  in  3  branch condition.
- rs1_data  in  XLEN  source operand 1.
- rs2_data  in  XLEN  source operand 2.
- imm  in  XLEN  sign-extended immediate.
- PC  in  XLEN  instruction PC.
- tag_in  in  TAG_W  issue tag.
- busy  out  1  unit occupied; issue must hold off.
- done  out  1  one-cycle result-valid pulse.
- tag_out  out  TAG_W  tag of the completed op.
- PC_jump  out  XLEN  target address.
- PC_wb  out  XLEN  link value, PC+4.
- cmp_res  out  1  raw comparison result.
- taken  out  1  redirect required.
- misalign  out  1  target bit 1 set.

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, counter 0, all operand registers 0.
- Accept: at a rising edge with EN=1, busy=0 and flush=0:
  - latch JAL, JALR, cmp_ctrl, rs1, rs2, imm, PC and tag;
  - go to BUSY; counter loads LATENCY-1.
- EN while busy=1 is ignored. No queueing and no error flag.
- States:
  - IDLE (busy=0).
  - BUSY (busy=1): counter decrements each edge. At the edge where counter==0, go to IDLE and register the results with done=1.
- Timing: busy is high for exactly LATENCY cycles after the accept edge. done is high for exactly the following cycle.
- Back-to-back issue: busy=0 in the done cycle, so a new EN there is accepted. The next done arrives LATENCY+1 cycles after the previous one.
- Outputs PC_jump, PC_wb, cmp_res, taken, misalign and tag_out are registered. They update only on the done edge and hold their values until the next done.
- Arithmetic (all modulo 2^XLEN, carries discarded):
  - PC_wb = PC+4.
  - JALR target = (rs1+imm) with bit 0 forced to 0.
  - Otherwise target = PC+imm.
  - JALR has priority over JAL if both are set.
- cmp_ctrl encoding:
  - 001 EQ, 010 NE, 011 LT (signed), 100 LTU, 101 GE (signed), 110 GEU.
  - 000 and 111 give cmp_res=0.
- taken = JAL | JALR | cmp_res. misalign = PC_jump[1]. misalign is reported whether or not taken is set.
- Flush (sampled at an edge):
  - In BUSY: return to IDLE with no done pulse; result registers keep their old values.
  - If flush coincides with the done edge: done is suppressed.
  - flush with EN in the same cycle: EN is dropped.
  - Flush in IDLE has no effect.
- Async reset mid-operation: the op is abandoned immediately and no done follows.
- LATENCY=1: busy is high for one cycle, then done.

Test Plan:
1. Reset then BEQ, LATENCY=2. Stimulus: rs1=rs2=0x10, PC=0x100, imm=0x20, cmp_ctrl=001, tag=3. Required: busy high for 2 cycles, then done=1 with PC_jump=0x120, PC_wb=0x104, cmp_res=1, taken=1, tag_out=3.
2. Signed vs unsigned compare. Stimulus: rs1=0xFFFFFFFF, rs2=1. Required: cmp_ctrl=011 gives cmp_res=1; cmp_ctrl=100 gives cmp_res=0 and taken=0.
3. JALR LSB clear and wrap-around. Stimulus: JALR=1, rs1=0xFFFFFFFF, imm=4. Required: PC_jump=0x00000002, misalign=1, taken=1. Also PC=0xFFFFFFFC gives PC_wb=0.
4. Back-pressure and back-to-back. Stimulus: EN held high continuously with tags 1, 2, 3 (each tag is the one presented when busy=0). Required: EN during busy cycles ignored; done pulses carry tags 1, 2, 3, spaced LATENCY+1 cycles apart.
5. Flush. Stimulus: flush in BUSY, in the done-edge cycle, and together with EN. Required: no done pulse in all three cases, busy=0 afterwards, previous outputs unchanged.
6. Async reset mid-op. Stimulus: drop rst between clock edges while busy=1. Required: busy=0 and all outputs 0 immediately; no done after rst rises.

Source files
------------

// File: rtl/fu_jump_pipe.sv
// Branch/jump functional unit: resolves branch, JAL and JALR after LATENCY cycles.
// Ports: clk, rst (async active-low), EN/flush/issue operands in; busy, done, tag and results out.
module fu_jump_pipe #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic             flush,
  input  logic             JAL,
  input  logic             JALR,
  input  logic [2:0]       cmp_ctrl,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  PC,
  input  logic [TAG_W-1:0] tag_in,
  output logic             busy,
  output logic             done,
  output logic [TAG_W-1:0] tag_out,
  output logic [XLEN-1:0]  PC_jump,
  output logic [XLEN-1:0]  PC_wb,
  output logic             cmp_res,
  output logic             taken,
  output logic             misalign
);

  generate
    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
      $error("fu_jump_pipe: LATENCY must be 1..8");
    end
  endgenerate

  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state, state_nx;
  logic [2:0] cnt;
  logic       accept;
  logic       finish;

  logic             jal_q;
  logic             jalr_q;
  logic [2:0]       cmp_q;
  logic [XLEN-1:0]  rs1_q;
  logic [XLEN-1:0]  rs2_q;
  logic [XLEN-1:0]  imm_q;
  logic [XLEN-1:0]  pc_q;
  logic [TAG_W-1:0] tag_q;

  logic            cmp_nx;
  logic [XLEN-1:0] sum_r;
  logic [XLEN-1:0] tgt_nx;
  logic [XLEN-1:0] wb_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      jal_q    <= 1'b0;
      jalr_q   <= 1'b0;
      cmp_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      tag_q    <= '0;
      tag_out  <= '0;
      PC_jump  <= '0;
      PC_wb    <= '0;
      cmp_res  <= 1'b0;
      taken    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= finish;
      if (accept) begin
        jal_q  <= JAL;
        jalr_q <= JALR;
        cmp_q  <= cmp_ctrl;
        rs1_q  <= rs1_data;
        rs2_q  <= rs2_data;
        imm_q  <= imm;
        pc_q   <= PC;
        tag_q  <= tag_in;
        cnt    <= CNT_INIT;
      end else if (state_nx == IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt - 3'd1;
      end
      if (finish) begin
        tag_out  <= tag_q;
        PC_jump  <= tgt_nx;
        PC_wb    <= wb_nx;
        cmp_res  <= cmp_nx;
        taken    <= jal_q | jalr_q | cmp_nx;
        misalign <= tgt_nx[1];
      end
    end
  end

  // flush outranks both a new issue and a completing op
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    finish   = 1'b0;
    unique case (state)
      IDLE: begin
        if (EN && !flush) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          state_nx = IDLE;
        end else if (cnt == 3'd0) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == BUSY);
    sum_r = rs1_q + imm_q;
    wb_nx = pc_q + XLEN'(4);
    if (jalr_q) begin
      tgt_nx = {sum_r[XLEN-1:1], 1'b0};
    end else begin
      tgt_nx = pc_q + imm_q;
    end
    cmp_nx = 1'b0;
    unique case (1'b1)
      (cmp_q == 3'b001): cmp_nx = (rs1_q == rs2_q);
      (cmp_q == 3'b010): cmp_nx = (rs1_q != rs2_q);
      (cmp_q == 3'b011): cmp_nx = ($signed(rs1_q) < $signed(rs2_q));
      (cmp_q == 3'b100): cmp_nx = (rs1_q < rs2_q);
      (cmp_q == 3'b101): cmp_nx = ($signed(rs1_q) >= $signed(rs2_q));
      (cmp_q == 3'b110): cmp_nx = (rs1_q >= rs2_q);
      default:           cmp_nx = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_fu_jump_pipe.sv
// Self-checking bench for fu_jump_pipe (LATENCY=2) with directed and random ops.
// Drives inputs 1 time unit after each rising edge and samples there too.
module tb_fu_jump_pipe;

  localparam int XLEN = 32;
  localparam int LAT  = 2;
  localparam int TW   = 4;

  typedef struct packed {
    logic            jal;
    logic            jalr;
    logic [2:0]      cmp;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [TW-1:0]   tag;
  } op_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            EN = 1'b0;
  logic            flush = 1'b0;
  logic            JAL = 1'b0;
  logic            JALR = 1'b0;
  logic [2:0]      cmp_ctrl = '0;
  logic [XLEN-1:0] rs1_data = '0;
  logic [XLEN-1:0] rs2_data = '0;
  logic [XLEN-1:0] imm = '0;
  logic [XLEN-1:0] PC = '0;
  logic [TW-1:0]   tag_in = '0;
  logic            busy;
  logic            done;
  logic [TW-1:0]   tag_out;
  logic [XLEN-1:0] PC_jump;
  logic [XLEN-1:0] PC_wb;
  logic            cmp_res;
  logic            taken;
  logic            misalign;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [XLEN-1:0] e_tgt = '0;
  logic [XLEN-1:0] e_wb = '0;
  logic            e_c = 1'b0;
  logic            e_tk = 1'b0;
  logic            e_ms = 1'b0;
  logic [TW-1:0]   e_tag = '0;

  fu_jump_pipe #(
    .XLEN(XLEN),
    .LATENCY(LAT),
    .TAG_W(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .EN(EN),
    .flush(flush),
    .JAL(JAL),
    .JALR(JALR),
    .cmp_ctrl(cmp_ctrl),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .imm(imm),
    .PC(PC),
    .tag_in(tag_in),
    .busy(busy),
    .done(done),
    .tag_out(tag_out),
    .PC_jump(PC_jump),
    .PC_wb(PC_wb),
    .cmp_res(cmp_res),
    .taken(taken),
    .misalign(misalign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
    n_vec++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the op's results straight from the ISA-level rules.
  task automatic model(input op_t o);
    logic [XLEN-1:0] s;
    case (o.cmp)
      3'd1: e_c = (o.rs1 == o.rs2);
      3'd2: e_c = (o.rs1 != o.rs2);
      3'd3: e_c = ($signed(o.rs1) < $signed(o.rs2));
      3'd4: e_c = (o.rs1 < o.rs2);
      3'd5: e_c = ($signed(o.rs1) >= $signed(o.rs2));
      3'd6: e_c = (o.rs1 >= o.rs2);
      default: e_c = 1'b0;
    endcase
    s = o.rs1 + o.imm;
    e_tgt = o.jalr ? (s & ~XLEN'(1)) : (o.pc + o.imm);
    e_wb  = o.pc + 32'd4;
    e_tk  = o.jal | o.jalr | e_c;
    e_ms  = e_tgt[1];
    e_tag = o.tag;
  endtask

  task automatic drive(input op_t o);
    JAL      = o.jal;
    JALR     = o.jalr;
    cmp_ctrl = o.cmp;
    rs1_data = o.rs1;
    rs2_data = o.rs2;
    imm      = o.imm;
    PC       = o.pc;
    tag_in   = o.tag;
  endtask

  task automatic chk_outs(input string t);
    chk({t, ".tag"}, 64'(tag_out), 64'(e_tag));
    chk({t, ".pcj"}, 64'(PC_jump), 64'(e_tgt));
    chk({t, ".pcwb"}, 64'(PC_wb), 64'(e_wb));
    chk({t, ".cmp"}, 64'(cmp_res), 64'(e_c));
    chk({t, ".taken"}, 64'(taken), 64'(e_tk));
    chk({t, ".mis"}, 64'(misalign), 64'(e_ms));
  endtask

  task automatic run_op(input string t, input op_t o);
    chk({t, ".idle"}, 64'(busy), 64'd0);
    drive(o);
    EN = 1'b1;
    tick();
    EN = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      chk({t, ".busy"}, 64'(busy), 64'd1);
      chk({t, ".nodone"}, 64'(done), 64'd0);
      tick();
    end
    model(o);
    chk({t, ".done"}, 64'(done), 64'd1);
    chk({t, ".bz0"}, 64'(busy), 64'd0);
    chk_outs(t);
    tick();
    chk({t, ".pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    op_t o;
    int last;
    rst = 1'b0;
    #1;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk_outs("rst");
    #13;
    rst = 1'b1;
    tick();

    o = '{jal: 0, jalr: 0, cmp: 3'b001, rs1: 32'h10, rs2: 32'h10,
          imm: 32'h20, pc: 32'h100, tag: 4'd3};
    run_op("beq", o);
    chk("beq.k.pcj", 64'(PC_jump), 64'h120);
    chk("beq.k.pcwb", 64'(PC_wb), 64'h104);
    chk("beq.k.tk", 64'(taken), 64'd1);

    o = '{jal: 0, jalr: 0, cmp: 3'b011, rs1: 32'hFFFFFFFF, rs2: 32'h1,
          imm: 32'h8, pc: 32'h200, tag: 4'd4};
    run_op("blt", o);
    chk("blt.k.cmp", 64'(cmp_res), 64'd1);
    o.cmp = 3'b100;
    o.tag = 4'd5;
    run_op("bltu", o);
    chk("bltu.k.cmp", 64'(cmp_res), 64'd0);
    chk("bltu.k.tk", 64'(taken), 64'd0);

    o = '{jal: 0, jalr: 1, cmp: 3'b000, rs1: 32'hFFFFFFFF, rs2: 32'h0,
          imm: 32'h4, pc: 32'hFFFFFFFC, tag: 4'd6};
    run_op("jalr", o);
    chk("jalr.k.pcj", 64'(PC_jump), 64'h2);
    chk("jalr.k.mis", 64'(misalign), 64'd1);
    chk("jalr.k.tk", 64'(taken), 64'd1);
    chk("jalr.k.wb", 64'(PC_wb), 64'h0);

    // back-to-back with EN held high; junk tags while busy
    o = '{jal: 1, jalr: 0, cmp: 3'b000, rs1: 32'h0, rs2: 32'h0,
          imm: 32'h40, pc: 32'h1000, tag: 4'd1};
    drive(o);
    EN = 1'b1;
    last = 0;
    for (int k = 1; k <= 3; k++) begin
      tag_in = 4'(k);
      tick();
      tag_in = 4'(k + 8);
      for (int i = 0; i < LAT; i++) begin
        chk("b2b.busy", 64'(busy), 64'd1);
        tick();
      end
      chk("b2b.done", 64'(done), 64'd1);
      chk("b2b.tag", 64'(tag_out), 64'(k));
      if (k > 1) chk("b2b.gap", 64'(cyc - last), 64'(LAT + 1));
      last = cyc;
    end
    EN = 1'b0;
    o.tag = 4'd3;
    model(o);
    chk_outs("b2b");
    tick();
    chk("b2b.end", 64'(done), 64'd0);

    // flush while busy
    o = '{jal: 0, jalr: 0, cmp: 3'b010, rs1: 32'h5, rs2: 32'h6,
          imm: 32'h300, pc: 32'h50, tag: 4'd9};
    drive(o);
    EN = 1'b1;
    tick();
    EN = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl1.busy", 64'(busy), 64'd0);
    for (int i = 0; i < LAT + 1; i++) begin
      chk("fl1.nodone", 64'(done), 64'd0);
      tick();
    end
    chk_outs("fl1");

    // flush on the completion edge
    EN = 1'b1;
    tick();
    EN = 1'b0;
    for (int i = 0; i < LAT - 1; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl2.done", 64'(done), 64'd0);
    chk("fl2.busy", 64'(busy), 64'd0);
    tick();
    chk("fl2.done2", 64'(done), 64'd0);
    chk_outs("fl2");

    // flush together with EN in idle
    EN = 1'b1;
    flush = 1'b1;
    tick();
    EN = 1'b0;
    flush = 1'b0;
    chk("fl3.busy", 64'(busy), 64'd0);
    for (int i = 0; i < LAT + 1; i++) begin
      chk("fl3.nodone", 64'(done), 64'd0);
      tick();
    end
    chk_outs("fl3");

    // random ops against the reference
    for (int n = 0; n < 40; n++) begin
      o.jal  = ($urandom_range(0, 5) == 0);
      o.jalr = ($urandom_range(0, 5) == 0);
      o.cmp  = 3'($urandom_range(0, 7));
      o.rs1  = $urandom;
      o.rs2  = ($urandom_range(0, 3) == 0) ? o.rs1 : $urandom;
      o.imm  = $urandom;
      o.pc   = $urandom;
      o.tag  = 4'($urandom);
      run_op("rnd", o);
    end

    // async reset while busy
    drive(o);
    EN = 1'b1;
    tick();
    EN = 1'b0;
    chk("ar.busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    e_tgt = '0;
    e_wb  = '0;
    e_c   = 1'b0;
    e_tk  = 1'b0;
    e_ms  = 1'b0;
    e_tag = '0;
    chk("ar.busy0", 64'(busy), 64'd0);
    chk("ar.done0", 64'(done), 64'd0);
    chk_outs("ar");
    #1;
    rst = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      chk("ar.nodone", 64'(done), 64'd0);
    end
    chk_outs("ar.post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
